avl_mem_resp: RTL and testbench
===============================

// Module: avl_mem_resp
// PURPOSE
//  Avalon-MM responder (slave) modelling the external-memory-interface side seen by the frame buffer.
//  Answers avl_write_req / avl_read_req with avl_ready backpressure, a fixed-latency read-data return
//  and a ram_rdy init-done indication. Backed by a local on-chip RAM.
//  Used as the memory end in frame-buffer benches and as a stand-in on boards without DDR.
// PARAMETERS
//  DATA_WIDTH    32  data bus width
//  ADDR_WIDTH    29  avl_addr width, matching the frame buffer
//  MEM_AW        12  implemented RAM address bits; depth = 2**MEM_AW words
//  INIT_CYCLES   16  cycles after reset release before ram_rdy rises (>=1)
//  RD_LATENCY     4  cycles from read accept edge to avl_rdata_valid (>=1)
//  STALL_PERIOD   8  a 1-cycle avl_ready drop after every N accepted commands; 0 disables
// PORTS
//  clk              in   1           clock
//  reset            in   1           synchronous, active-low
//  avl_write_req    in   1           write command
//  avl_read_req     in   1           read command
//  avl_addr         in   ADDR_WIDTH  word address
//  avl_wdata        in   DATA_WIDTH  write data
//  avl_ready        out  1           responder can accept a command this cycle
//  avl_rdata        out  DATA_WIDTH  read data
//  avl_rdata_valid  out  1           avl_rdata valid, 1-cycle pulse per read
//  ram_rdy          out  1           init done; stays high until the next reset
//  err              out  1           sticky protocol/range error
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=INIT, init counter=0, stall counter=0, read pipe flushed.
//   Outputs at reset: ram_rdy=0, avl_ready=0, avl_rdata_valid=0, avl_rdata=0, err=0.
//   RAM contents are NOT cleared.
//  FSM states, all outputs registered:
//   INIT: counts INIT_CYCLES cycles, then ram_rdy<=1, avl_ready<=1, go to RUN.
//   RUN: avl_ready=1. Accept = (req && avl_ready) at posedge. Stall counter counts accepts.
//     On the STALL_PERIOD-th accept: counter<=0, avl_ready<=0, go to STALL.
//   STALL: one cycle with avl_ready=0. Requests held during this cycle are ignored.
//     Then avl_ready<=1, go to RUN.
//  Write accept: mem[avl_addr[MEM_AW-1:0]] <= avl_wdata.
//  Read accept: RAM read at the accept edge. Data emerges after RD_LATENCY-1 more pipe stages.
//   avl_rdata_valid is high exactly RD_LATENCY cycles after the accept edge.
//   Reads return in order. One accept per cycle, so the pipe cannot overflow.
//   avl_rdata holds its last value when valid=0.
//  Read issued the cycle after a write to the same address returns the new data (write-first ordering).
//  avl_write_req && avl_read_req together while avl_ready=1: neither command is accepted,
//   err<=1, and the cycle does not count as an accept.
//  avl_addr[ADDR_WIDTH-1:MEM_AW] != 0 on accept: err<=1.
//   Out-of-range write is dropped. Out-of-range read returns 0 with normal valid timing.
//  Requests while ram_rdy=0 are ignored and do not set err.
//  Reset mid-operation: in-flight reads are discarded and no valid pulse follows.
//   Init restarts from 0.
// CONFIGURATION
//  AVL_RESP_STATS_EN defined: adds ports wr_count and rd_count (out, 32 bits each).
//   They count accepted writes and reads, clear on reset, and wrap at 2**32.
//   err-causing dual requests are not counted. Out-of-range accepts are counted.
//  AVL_RESP_STATS_EN undefined: ports and counters are absent. All other behaviour is identical.
// TESTING
//  T1 reset release, INIT_CYCLES=16 -> ram_rdy=0 and avl_ready=0 for 16 cycles, both rise on the 17th edge.
//  T2 write 0xDEADBEEF @addr 5, then read addr 5 next cycle -> avl_rdata=0xDEADBEEF,
//     valid exactly 4 cycles after the read accept edge.
//  T3 8 back-to-back writes (addr 0..7) with STALL_PERIOD=8 -> avl_ready low for 1 cycle after the 8th accept.
//     A 9th write held through the stall is accepted the next cycle. Read addr 0..7 back -> data matches.
//  T4 write and read req asserted together -> err=1, RAM unchanged, no valid pulse.
//     Read of addr 1<<MEM_AW -> data 0, err=1.
//  T5 3 reads issued, reset asserted 2 cycles later -> no avl_rdata_valid pulses.
//     Earlier-written RAM data is still readable after re-init.
//  T6 with AVL_RESP_STATS_EN: 10 writes and 6 reads -> wr_count=10, rd_count=6. Reset -> both 0.

Source files
------------

// File: rtl/avl_mem_resp_if.sv
// Avalon-MM command/response bundle between the frame buffer (master) and
// the memory responder (slave).
interface avl_mem_resp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29
);
    logic                  avl_write_req;
    logic                  avl_read_req;
    logic [ADDR_WIDTH-1:0] avl_addr;
    logic [DATA_WIDTH-1:0] avl_wdata;
    logic                  avl_ready;
    logic [DATA_WIDTH-1:0] avl_rdata;
    logic                  avl_rdata_valid;

    modport slave (
        input  avl_write_req, avl_read_req, avl_addr, avl_wdata,
        output avl_ready, avl_rdata, avl_rdata_valid
    );

    modport master (
        output avl_write_req, avl_read_req, avl_addr, avl_wdata,
        input  avl_ready, avl_rdata, avl_rdata_valid
    );
endinterface

// File: rtl/avl_mem_resp.sv
// Avalon-MM memory responder backed by on-chip RAM: init delay, periodic stall, fixed read latency.
// Optional AVL_RESP_STATS_EN adds wr_count/rd_count accept counters.
module avl_mem_resp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 29,
    parameter int MEM_AW       = 12,
    parameter int INIT_CYCLES  = 16,
    parameter int RD_LATENCY   = 4,
    parameter int STALL_PERIOD = 8
) (
    input  logic                clk,
    input  logic                reset,
    avl_mem_resp_if.slave       avl,
    output logic                ram_rdy,
    output logic                err
`ifdef AVL_RESP_STATS_EN
    ,
    output logic [31:0]         wr_count,
    output logic [31:0]         rd_count
`endif
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_init_cnt;
    logic [31:0]           r_stall_cnt;
    logic                  w_ready_nxt;
    logic                  w_rdy_nxt;

    logic                  w_wr;
    logic                  w_rd;
    logic                  w_dual;
    logic                  w_acc;
    logic                  w_oor;
    logic                  w_stall_hit;
    logic [MEM_AW-1:0]     w_idx;

    logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];
    logic [DATA_WIDTH-1:0] r_pd  [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_pv;

    assign w_wr   = avl.avl_write_req;
    assign w_rd   = avl.avl_read_req;
    assign w_idx  = avl.avl_addr[MEM_AW-1:0];
    assign w_oor  = (avl.avl_addr >> MEM_AW) != '0;
    // reset gates acceptance so a request seen on the reset edge cannot touch the RAM
    assign w_dual = reset && (r_state == S_RUN) && w_wr && w_rd;
    assign w_acc  = reset && (r_state == S_RUN) && (w_wr ^ w_rd);
    assign w_stall_hit = (STALL_PERIOD != 0) && w_acc &&
                         (r_stall_cnt == 32'(STALL_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_INIT;
            r_init_cnt    <= '0;
            r_stall_cnt   <= '0;
            avl.avl_ready <= 1'b0;
            ram_rdy       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            avl.avl_ready <= w_ready_nxt;
            ram_rdy       <= w_rdy_nxt;
            if (r_state == S_INIT && r_init_cnt != 32'(INIT_CYCLES))
                r_init_cnt <= r_init_cnt + 32'd1;
            if (w_acc)
                r_stall_cnt <= w_stall_hit ? '0 : r_stall_cnt + 32'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_init_cnt == 32'(INIT_CYCLES)) w_state_nxt = S_RUN;
            S_RUN:   if (w_stall_hit) w_state_nxt = S_STALL;
            S_STALL: w_state_nxt = S_RUN;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        w_ready_nxt = (w_state_nxt == S_RUN);
        w_rdy_nxt   = (w_state_nxt != S_INIT);
    end

    always_ff @(posedge clk) begin
        if (w_acc && w_wr && !w_oor)
            r_mem[w_idx] <= avl.avl_wdata;
    end

    // data stages carry no reset; only the valid bits decide what reaches the output
    always_ff @(posedge clk) begin
        r_pd[0] <= w_oor ? '0 : r_mem[w_idx];
        for (int unsigned i = 1; i < RD_LATENCY; i++)
            r_pd[i] <= r_pd[i-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pv                <= '0;
            avl.avl_rdata_valid <= 1'b0;
            avl.avl_rdata       <= '0;
            err                 <= 1'b0;
        end else begin
            r_pv[0] <= w_acc && w_rd;
            for (int unsigned i = 1; i < RD_LATENCY; i++)
                r_pv[i] <= r_pv[i-1];
            avl.avl_rdata_valid <= r_pv[RD_LATENCY-1];
            if (r_pv[RD_LATENCY-1])
                avl.avl_rdata <= r_pd[RD_LATENCY-1];
            if (w_dual || (w_acc && w_oor))
                err <= 1'b1;
        end
    end

`ifdef AVL_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (w_acc && w_wr) wr_count <= wr_count + 32'd1;
            if (w_acc && w_rd) rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avl_mem_resp.sv
// Directed self-checking bench for avl_mem_resp (default parameters).
module tb_avl_mem_resp;
    localparam int DW  = 32;
    localparam int AW  = 29;
    localparam int MAW = 12;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic ram_rdy;
    logic err;
`ifdef AVL_RESP_STATS_EN
    logic [31:0] wr_count;
    logic [31:0] rd_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avl_mem_resp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    avl_mem_resp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_AW(MAW),
        .INIT_CYCLES(16), .RD_LATENCY(4), .STALL_PERIOD(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avl(bus),
        .ram_rdy(ram_rdy),
        .err(err)
`ifdef AVL_RESP_STATS_EN
        ,
        .wr_count(wr_count),
        .rd_count(rd_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.avl_write_req = 1'b0;
        bus.avl_read_req  = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.avl_write_req = wr;
        bus.avl_read_req  = rd;
        bus.avl_addr      = a;
        bus.avl_wdata     = d;
        while (!bus.avl_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.avl_ready) begin
            errors++;
            $display("FAIL issue_ready_timeout got=%0b want=1", bus.avl_ready);
        end
        tick();
        idle();
    endtask

    task automatic reinit();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (17) tick();
    endtask

    task automatic test_reset();
        idle();
        bus.avl_addr  = '0;
        bus.avl_wdata = '0;
        reset = 1'b0;
        tick();
        tick();
        checks++; if (ram_rdy !== 1'b0) begin errors++; $display("FAIL rst_ram_rdy got=%0b want=0", ram_rdy); end
        checks++; if (bus.avl_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b want=0", bus.avl_ready); end
        checks++; if (bus.avl_rdata_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b want=0", bus.avl_rdata_valid); end
        checks++; if (bus.avl_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h want=0", bus.avl_rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b want=0", err); end
        reset = 1'b1;
        // dual out-of-range requests during init must be ignored without raising err
        bus.avl_write_req = 1'b1;
        bus.avl_read_req  = 1'b1;
        bus.avl_addr      = 29'(1 << MAW);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) idle();
            tick();
            checks++; if (ram_rdy !== 1'b0) begin errors++; $display("FAIL init_ram_rdy cyc=%0d got=%0b want=0", i, ram_rdy); end
            checks++; if (bus.avl_ready !== 1'b0) begin errors++; $display("FAIL init_ready cyc=%0d got=%0b want=0", i, bus.avl_ready); end
        end
        tick();
        checks++; if (ram_rdy !== 1'b1) begin errors++; $display("FAIL init_done_ram_rdy got=%0b want=1", ram_rdy); end
        checks++; if (bus.avl_ready !== 1'b1) begin errors++; $display("FAIL init_done_ready got=%0b want=1", bus.avl_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err got=%0b want=0", err); end
    endtask

    task automatic test_write_read();
        issue(1'b1, 1'b0, 29'd5, 32'hDEADBEEF);
        checks++; if (bus.avl_ready !== 1'b1) begin errors++; $display("FAIL t2_ready got=%0b want=1", bus.avl_ready); end
        issue(1'b0, 1'b1, 29'd5, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (bus.avl_rdata_valid !== 1'b0) begin errors++; $display("FAIL t2_early_valid cyc=%0d got=%0b want=0", k, bus.avl_rdata_valid); end
        end
        tick();
        checks++; if (bus.avl_rdata_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got=%0b want=1", bus.avl_rdata_valid); end
        checks++; if (bus.avl_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_rdata got=%h want=deadbeef", bus.avl_rdata); end
        tick();
        checks++; if (bus.avl_rdata_valid !== 1'b0) begin errors++; $display("FAIL t2_valid_pulse got=%0b want=0", bus.avl_rdata_valid); end
        checks++; if (bus.avl_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_rdata_hold got=%h want=deadbeef", bus.avl_rdata); end
    endtask

    task automatic test_stall();
        int n;
        reinit();
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.avl_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_pre addr=%0d got=%0b want=1", i, bus.avl_ready); end
            issue(1'b1, 1'b0, 29'(i), 32'hA000_0000 | 32'(i));
        end
        checks++; if (bus.avl_ready !== 1'b0) begin errors++; $display("FAIL t3_stall_ready got=%0b want=0", bus.avl_ready); end
        bus.avl_write_req = 1'b1;
        bus.avl_addr      = 29'd8;
        bus.avl_wdata     = 32'hA000_0008;
        tick();
        checks++; if (bus.avl_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_after got=%0b want=1", bus.avl_ready); end
        tick();
        idle();
        for (int i = 0; i <= 8; i++) begin
            issue(1'b0, 1'b1, 29'(i), 32'h0);
            n = 0;
            while (!bus.avl_rdata_valid && n < 10) begin
                tick();
                n++;
            end
            checks++; if (bus.avl_rdata_valid !== 1'b1) begin errors++; $display("FAIL t3_rd_valid addr=%0d got=%0b want=1", i, bus.avl_rdata_valid); end
            checks++; if (bus.avl_rdata !== (32'hA000_0000 | 32'(i))) begin errors++; $display("FAIL t3_rd_data addr=%0d got=%h want=%h", i, bus.avl_rdata, 32'hA000_0000 | 32'(i)); end
        end
    endtask

    task automatic test_err();
        int n;
        int vcount;
        reinit();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err_clear got=%0b want=0", err); end
        bus.avl_write_req = 1'b1;
        bus.avl_read_req  = 1'b1;
        bus.avl_addr      = 29'd3;
        bus.avl_wdata     = 32'h1234_5678;
        tick();
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_dual_err got=%0b want=1", err); end
        vcount = 0;
        repeat (6) begin
            tick();
            if (bus.avl_rdata_valid) vcount++;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL t4_dual_valid got=%0d want=0", vcount); end
        issue(1'b0, 1'b1, 29'd3, 32'h0);
        n = 0;
        while (!bus.avl_rdata_valid && n < 10) begin tick(); n++; end
        checks++; if (bus.avl_rdata !== 32'hA000_0003) begin errors++; $display("FAIL t4_dual_ram got=%h want=a0000003", bus.avl_rdata); end

        reinit();
        issue(1'b1, 1'b0, 29'((1 << MAW) | 3), 32'h5555_5555);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_oor_wr_err got=%0b want=1", err); end
        issue(1'b0, 1'b1, 29'd3, 32'h0);
        n = 0;
        while (!bus.avl_rdata_valid && n < 10) begin tick(); n++; end
        checks++; if (bus.avl_rdata !== 32'hA000_0003) begin errors++; $display("FAIL t4_oor_wr_drop got=%h want=a0000003", bus.avl_rdata); end

        reinit();
        issue(1'b0, 1'b1, 29'd3, 32'h0);
        n = 0;
        while (!bus.avl_rdata_valid && n < 10) begin tick(); n++; end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_inrange_err got=%0b want=0", err); end
        issue(1'b0, 1'b1, 29'(1 << MAW), 32'h0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_oor_rd_err got=%0b want=1", err); end
        for (int k = 1; k <= 3; k++) tick();
        checks++; if (bus.avl_rdata_valid !== 1'b0) begin errors++; $display("FAIL t4_oor_early got=%0b want=0", bus.avl_rdata_valid); end
        tick();
        checks++; if (bus.avl_rdata_valid !== 1'b1) begin errors++; $display("FAIL t4_oor_valid got=%0b want=1", bus.avl_rdata_valid); end
        checks++; if (bus.avl_rdata !== 32'h0) begin errors++; $display("FAIL t4_oor_data got=%h want=0", bus.avl_rdata); end
    endtask

    task automatic test_reset_inflight();
        int n;
        int vcount;
        reinit();
        bus.avl_read_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.avl_addr = 29'(i);
            tick();
        end
        idle();
        tick();
        reset  = 1'b0;
        vcount = 0;
        tick();
        if (bus.avl_rdata_valid) vcount++;
        tick();
        if (bus.avl_rdata_valid) vcount++;
        reset = 1'b1;
        repeat (17) begin
            tick();
            if (bus.avl_rdata_valid) vcount++;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL t5_flush_valid got=%0d want=0", vcount); end
        checks++; if (bus.avl_ready !== 1'b1) begin errors++; $display("FAIL t5_reinit_ready got=%0b want=1", bus.avl_ready); end
        issue(1'b0, 1'b1, 29'd2, 32'h0);
        n = 0;
        while (!bus.avl_rdata_valid && n < 10) begin tick(); n++; end
        checks++; if (bus.avl_rdata_valid !== 1'b1) begin errors++; $display("FAIL t5_rd_valid got=%0b want=1", bus.avl_rdata_valid); end
        checks++; if (bus.avl_rdata !== 32'hA000_0002) begin errors++; $display("FAIL t5_rd_data got=%h want=a0000002", bus.avl_rdata); end
    endtask

`ifdef AVL_RESP_STATS_EN
    task automatic test_stats();
        reinit();
        checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL t6_wr_init got=%0d want=0", wr_count); end
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL t6_rd_init got=%0d want=0", rd_count); end
        for (int i = 0; i < 10; i++) issue(1'b1, 1'b0, 29'(20 + i), 32'(i));
        issue(1'b1, 1'b1, 29'd40, 32'h0);
        for (int i = 0; i < 6; i++) issue(1'b0, 1'b1, 29'(20 + i), 32'h0);
        repeat (6) tick();
        checks++; if (wr_count !== 32'd10) begin errors++; $display("FAIL t6_wr_count got=%0d want=10", wr_count); end
        checks++; if (rd_count !== 32'd6) begin errors++; $display("FAIL t6_rd_count got=%0d want=6", rd_count); end
        reset = 1'b0;
        tick();
        checks++; if (wr_count !== 32'd0) begin errors++; $display("FAIL t6_wr_rst got=%0d want=0", wr_count); end
        checks++; if (rd_count !== 32'd0) begin errors++; $display("FAIL t6_rd_rst got=%0d want=0", rd_count); end
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_stall();
        test_err();
        test_reset_inflight();
`ifdef AVL_RESP_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
